// File: rtl/logic_calc_ctrl_if.sv
// Bus between the button/switch front-end plus logic datapath and the
// logic-mode sequencer. master = front-end/datapath side, slave = sequencer.
interface logic_calc_ctrl_if;
    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 4;
    localparam int unsigned SW  = 3;

    logic [DW-1:0]  sw;
    logic [OPW-1:0] op_sel;
    logic           confirm;
    logic           back;
    logic [DW-1:0]  result_in;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
    logic [DW-1:0]  led;
    logic [SW-1:0]  state_code;
    logic           busy;
    logic           err;
    logic           done;

    modport master (
        output sw, op_sel, confirm, back, result_in,
        input  a, b, op, led, state_code, busy, err, done
    );

    modport slave (
        input  sw, op_sel, confirm, back, result_in,
        output a, b, op, led, state_code, busy, err, done
    );
endinterface

// File: rtl/logic_calc_ctrl.sv
// Bitwise-logic mode sequencer: op -> A -> B (skipped for NOT) -> one-cycle
// exec against the datapath -> show result until acknowledged.
module logic_calc_ctrl #(
    parameter int unsigned ERR_HOLD = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_calc_ctrl_if.slave bus
);
    localparam int unsigned DW    = 8;
    localparam int unsigned OPW   = 4;
    localparam int unsigned CNT_W = $clog2(ERR_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ERR_HOLD - 1);
    localparam logic [OPW-1:0]   OP_AND   = 4'b0001;
    localparam logic [OPW-1:0]   OP_OR    = 4'b0010;
    localparam logic [OPW-1:0]   OP_NOT   = 4'b0100;
    localparam logic [OPW-1:0]   OP_XOR   = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_OP = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_SHOW   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t         state;
    logic [DW-1:0]  a_reg;
    logic [DW-1:0]  b_reg;
    logic [DW-1:0]  res_reg;
    logic [OPW-1:0] op_reg;
    logic [CNT_W-1:0] err_cnt;

    logic           op_valid_c;
    logic           abort_c;
    logic           to_idle_c;
    logic [DW-1:0]  led_c;

    assign op_valid_c = (bus.op_sel == OP_AND) || (bus.op_sel == OP_OR) ||
                        (bus.op_sel == OP_NOT) || (bus.op_sel == OP_XOR);
    // back aborts everywhere except IDLE (nothing to abort) and EXEC (must complete)
    assign abort_c    = bus.back && (state != S_IDLE) && (state != S_EXEC);

    // Every path back to IDLE, including the unreachable encoding 7
    always_comb begin
        to_idle_c = abort_c;
        case (state)
            S_SHOW:  if (bus.confirm) to_idle_c = 1'b1;
            S_ERR:   if (err_cnt == CNT_LAST) to_idle_c = 1'b1;
            S_IDLE, S_GET_OP, S_GET_A, S_GET_B, S_EXEC: ;
            default: to_idle_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            op_reg  <= '0;
            err_cnt <= '0;
        end else if (to_idle_c) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            op_reg  <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.confirm) state <= S_GET_OP;
                S_GET_OP: begin
                    if (bus.confirm) begin
                        if (op_valid_c) begin
                            op_reg <= bus.op_sel;
                            state  <= S_GET_A;
                        end else begin
                            err_cnt <= '0;
                            state   <= S_ERR;
                        end
                    end
                end
                S_GET_A: begin
                    if (bus.confirm) begin
                        a_reg <= bus.sw;
                        if (op_reg == OP_NOT) begin
                            b_reg <= '0;
                            state <= S_EXEC;
                        end else begin
                            state <= S_GET_B;
                        end
                    end
                end
                S_GET_B: begin
                    if (bus.confirm) begin
                        b_reg <= bus.sw;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_reg <= bus.result_in;
                    state   <= S_SHOW;
                end
                S_ERR:   err_cnt <= err_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // LED prompt follows the live switches while an entry is pending
    always_comb begin
        led_c = '0;
        case (state)
            S_GET_OP:         led_c = {4'b0000, bus.op_sel};
            S_GET_A, S_GET_B: led_c = bus.sw;
            S_SHOW:           led_c = res_reg;
            S_ERR:            led_c = 8'hFF;
            default:          led_c = '0;
        endcase
    end

    assign bus.a          = a_reg;
    assign bus.b          = b_reg;
    assign bus.op         = ((state == S_EXEC) || (state == S_SHOW)) ? op_reg : '0;
    assign bus.led        = led_c;
    assign bus.state_code = 3'(state);
    assign bus.busy       = (state != S_IDLE);
    assign bus.err        = (state == S_ERR);
    assign bus.done       = (state == S_EXEC);
endmodule

// File: tb/tb_logic_calc_ctrl.sv
// Bench for logic_calc_ctrl: directed scenarios plus random button traffic,
// all checked cycle by cycle against a step-level reference model.
module tb_logic_calc_ctrl;
    localparam int unsigned ERR_HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic_calc_ctrl_if bus ();

    logic_calc_ctrl #(.ERR_HOLD(ERR_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] calc(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            4'b0001: return x & y;
            4'b0010: return x | y;
            4'b0100: return ~x;
            4'b1000: return x ^ y;
            default: return 8'h00;
        endcase
    endfunction

    // Combinational datapath stand-in
    assign bus.result_in = calc(bus.op, bus.a, bus.b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state numbers are the user-visible prompt codes
    int         m_st;
    logic [7:0] m_a, m_b, m_res;
    logic [3:0] m_op;
    int         m_left;

    task automatic model_reset();
        m_st = 0; m_a = 8'h00; m_b = 8'h00; m_res = 8'h00; m_op = 4'h0; m_left = 0;
    endtask

    task automatic model_step(input logic [7:0] s, input logic [3:0] o, input logic c, input logic bk);
        if (bk && m_st != 0 && m_st != 4) begin
            model_reset();
        end else begin
            case (m_st)
                0: if (c) m_st = 1;
                1: if (c) begin
                    if ($onehot(o)) begin m_op = o; m_st = 2; end
                    else begin m_left = ERR_HOLD; m_st = 6; end
                end
                2: if (c) begin
                    m_a = s;
                    if (m_op == 4'b0100) begin m_b = 8'h00; m_st = 4; end
                    else m_st = 3;
                end
                3: if (c) begin m_b = s; m_st = 4; end
                4: begin m_res = calc(m_op, m_a, m_b); m_st = 5; end
                5: if (c) model_reset();
                6: begin
                    m_left--;
                    if (m_left == 0) model_reset();
                end
                default: model_reset();
            endcase
        end
    endtask

    // One clock: drive at negedge, check current outputs, advance the model
    task automatic cycle(input logic [7:0] s, input logic [3:0] o, input logic c, input logic bk);
        logic [7:0] exp_led;
        @(negedge clk);
        bus.sw = s; bus.op_sel = o; bus.confirm = c; bus.back = bk;
        #1;
        case (m_st)
            1:       exp_led = {4'b0000, o};
            2, 3:    exp_led = s;
            5:       exp_led = m_res;
            6:       exp_led = 8'hFF;
            default: exp_led = 8'h00;
        endcase
        check("state_code", 32'(bus.state_code), 32'(m_st));
        check("a", 32'(bus.a), 32'(m_a));
        check("b", 32'(bus.b), 32'(m_b));
        check("op", 32'(bus.op), 32'((m_st == 4 || m_st == 5) ? m_op : 4'h0));
        check("led", 32'(bus.led), 32'(exp_led));
        check("busy", 32'(bus.busy), 32'(m_st != 0));
        check("err", 32'(bus.err), 32'(m_st == 6));
        check("done", 32'(bus.done), 32'(m_st == 4));
        model_step(s, o, c, bk);
    endtask

    task automatic idle_cycle();
        cycle(8'h00, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        bus.sw = 8'h00; bus.op_sel = 4'h0; bus.confirm = 1'b0; bus.back = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("rst_led", 32'(bus.led), 32'h0);
        check("rst_state", 32'(bus.state_code), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // AND flow
        cycle(8'h00, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'b0001, 1'b1, 1'b0);
        cycle(8'hF0, 4'h0, 1'b1, 1'b0);
        cycle(8'h3C, 4'h0, 1'b1, 1'b0);
        idle_cycle();
        check("and_exec_state", 32'(bus.state_code), 32'd4);
        check("and_exec_op", 32'(bus.op), 32'h1);
        check("and_exec_a", 32'(bus.a), 32'hF0);
        check("and_exec_b", 32'(bus.b), 32'h3C);
        check("and_done", 32'(bus.done), 32'h1);
        idle_cycle();
        check("and_show_led", 32'(bus.led), 32'h30);
        check("and_show_done", 32'(bus.done), 32'h0);
        cycle(8'h00, 4'h0, 1'b1, 1'b0);
        idle_cycle();
        check("and_ret_state", 32'(bus.state_code), 32'd0);
        check("and_ret_a", 32'(bus.a), 32'h0);
        check("and_ret_b", 32'(bus.b), 32'h0);

        // NOT skips operand B
        cycle(8'h00, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'b0100, 1'b1, 1'b0);
        cycle(8'hA5, 4'h0, 1'b1, 1'b0);
        idle_cycle();
        check("not_exec_state", 32'(bus.state_code), 32'd4);
        check("not_b", 32'(bus.b), 32'h0);
        idle_cycle();
        check("not_show_led", 32'(bus.led), 32'h5A);
        cycle(8'h00, 4'h0, 1'b1, 1'b0);

        // Invalid op: ERR held exactly ERR_HOLD cycles, confirms ignored
        cycle(8'h00, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'b0011, 1'b1, 1'b0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(8'h00, 4'h0, (m_st == 6), 1'b0);
            if (bus.err) n++;
            else break;
        end
        check("err_cycles", 32'(n), 32'(ERR_HOLD));
        check("err_exit_state", 32'(bus.state_code), 32'd0);

        // Abort in GET_B
        cycle(8'h00, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'b0010, 1'b1, 1'b0);
        cycle(8'h11, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'h0, 1'b0, 1'b1);
        idle_cycle();
        check("abort_state", 32'(bus.state_code), 32'd0);
        check("abort_a", 32'(bus.a), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);

        // back in EXEC ignored
        cycle(8'h00, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'b1000, 1'b1, 1'b0);
        cycle(8'h0F, 4'h0, 1'b1, 1'b0);
        cycle(8'hFF, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'h0, 1'b0, 1'b1);
        idle_cycle();
        check("exec_back_state", 32'(bus.state_code), 32'd5);
        check("exec_back_led", 32'(bus.led), 32'hF0);
        cycle(8'h00, 4'h0, 1'b1, 1'b0);

        // confirm and back together in GET_A
        cycle(8'h00, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'b0001, 1'b1, 1'b0);
        cycle(8'h77, 4'h0, 1'b1, 1'b1);
        idle_cycle();
        check("simul_state", 32'(bus.state_code), 32'd0);
        check("simul_a", 32'(bus.a), 32'h0);

        // Reset asserted mid-cycle while showing a result
        cycle(8'h00, 4'h0, 1'b1, 1'b0);
        cycle(8'h00, 4'b0001, 1'b1, 1'b0);
        cycle(8'hF0, 4'h0, 1'b1, 1'b0);
        cycle(8'h3C, 4'h0, 1'b1, 1'b0);
        idle_cycle();
        idle_cycle();
        check("pre_rst_led", 32'(bus.led), 32'h30);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(bus.led), 32'h0);
        check("async_rst_state", 32'(bus.state_code), 32'h0);
        check("async_rst_op", 32'(bus.op), 32'h0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;

        // Random button traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] o;
            o = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            cycle(8'($urandom), o, ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/logic_calc_ctrl.md
# logic_calc_ctrl

Sequencer for the calculator's bitwise-logic mode. It walks the user through three steps: choosing an operation, entering operand A, and entering operand B (skipped for NOT). It then drives the one-hot opcode and operands into the combinational logic-operation datapath, latches the returned result, and holds it on the LEDs until the user acknowledges. It sits between the debounced button/switch front-end and the logic-operation datapath, inside the calculate-mode top.

## Interface
- ERR_HOLD, default 50_000_000: cycles the error indication is held before returning to IDLE (minimum 1).
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- sw  in  8  operand switches, sampled on confirm.
- op_sel  in  4  opcode switches: one-hot 0001 AND, 0010 OR, 0100 NOT, 1000 XOR.
- confirm  in  1  single-cycle pulse, debounced upstream.
- back  in  1  single-cycle pulse, debounced upstream; aborts the sequence.
- result_in  in  8  result returned from the datapath.
- a  out  8  operand A to the datapath (registered).
- b  out  8  operand B to the datapath (registered).
- op  out  4  opcode to the datapath.
- led  out  8  LED display value.
- state_code  out  3  current state, for the 7-segment prompt.
- busy  out  1  high in every state except IDLE.
- err  out  1  high in ERR.
- done  out  1  one-cycle pulse when a result is latched.

## Operation
- States and codes: IDLE=0, GET_OP=1, GET_A=2, GET_B=3, EXEC=4, SHOW=5, ERR=6. State 7 is unreachable; if reached, go to IDLE next cycle.
- IDLE: on confirm, go to GET_OP.
- GET_OP, on confirm:
  - op_sel is one of the four legal codes: latch it into op_reg and go to GET_A.
  - Otherwise (0000, multi-hot): go to ERR, clear the error counter, leave op_reg unchanged.
- GET_A: on confirm, a <= sw.
  - If op_reg=0100: b <= 0 and go to EXEC.
  - Otherwise go to GET_B.
- GET_B: on confirm, b <= sw and go to EXEC.
- EXEC: lasts exactly one cycle.
  - op = op_reg.
  - At the end of the cycle, res_reg <= result_in, done=1 for that cycle, next state SHOW.
- SHOW: op = op_reg (datapath inputs stay stable). On confirm, go to IDLE.
- ERR: the counter increments every cycle; at count ERR_HOLD-1, go to IDLE. confirm is ignored in ERR.
- back: in any state other than IDLE and EXEC, go to IDLE next cycle.
  - back has priority over a simultaneous confirm.
  - back in IDLE or EXEC is ignored; EXEC always completes to SHOW.
- Leaving to IDLE (by confirm in SHOW, back, or ERR timeout): a, b, op_reg and res_reg are cleared to 0.
- op output: op_reg in EXEC and SHOW, 4'b0000 otherwise.
- led, combinational from state and registers:
  - IDLE: 0.
  - GET_OP: {4'b0, op_sel}.
  - GET_A and GET_B: sw (live).
  - EXEC: 0.
  - SHOW: res_reg.
  - ERR: 8'hFF.
- Width rule: all data is 8 bits with no arithmetic. The ERR counter is $clog2(ERR_HOLD+1) bits wide and must not wrap before the timeout.

## Timing
- Reset values: state IDLE; a=0, b=0, op_reg=0, res_reg=0, op=0, led=0, state_code=0, busy=0, err=0, done=0; error counter 0.
- Assertion of rst_n=0 takes effect immediately, mid-sequence included. Deassertion is used synchronously (release flop upstream).
- All state and register updates happen on the rising edge of clk. Outputs reflect the new state in the same cycle, after that edge.
- Latency: the confirm pulse in GET_B (or in GET_A for NOT) puts the state in EXEC on the next edge. The edge after that enters SHOW with res_reg valid and done already seen high during EXEC. This gives 2 cycles from the final confirm to the result on led.
- A confirm lasting more than one cycle is out of contract; each high cycle counts as one confirm.
- ERR duration: exactly ERR_HOLD cycles with err=1, then IDLE.

## Test plan
- AND flow:
  - Stimulus: confirm; op_sel=0001 + confirm; sw=8'hF0 + confirm; sw=8'h3C + confirm.
  - Required: EXEC for 1 cycle with op=0001, a=F0, b=3C; done for 1 cycle; SHOW with led=8'h30; a further confirm returns to IDLE with all registers 0.
- NOT skip:
  - Stimulus: op_sel=0100; sw=8'hA5 + confirm in GET_A.
  - Required: next state EXEC (GET_B never entered), b=0, led in SHOW = 8'h5A.
- Invalid op, with ERR_HOLD=4:
  - Stimulus: op_sel=0011 + confirm in GET_OP.
  - Required: err=1 and led=8'hFF for exactly 4 cycles, confirms ignored, then IDLE with err=0.
- Abort:
  - Stimulus: back in GET_B with a=8'h11 latched.
  - Required: IDLE next cycle, a=0, busy=0. back during EXEC is ignored and SHOW is reached.
- Simultaneous:
  - Stimulus: confirm and back in the same cycle in GET_A.
  - Required: IDLE, a not loaded.
- Reset:
  - Stimulus: rst_n low mid-cycle while in SHOW with led=8'h30.
  - Required: led=0, state_code=0, op=0 immediately, before the next clock edge.
